// File: rtl/noc_avmm_responder_pkg.sv
// Shared definitions for the NoC AVMM test responder: address map, CTRL layout,
// FSM state encoding and the byte-enable merge helper.
package noc_avmm_resp_pkg;

  localparam logic [17:0] WADDR_ID       = 18'h00000;
  localparam logic [17:0] WADDR_SCRATCH  = 18'h00001;
  localparam logic [17:0] WADDR_WR_COUNT = 18'h00002;
  localparam logic [17:0] WADDR_RD_COUNT = 18'h00003;
  localparam logic [17:0] WADDR_CTRL     = 18'h00004;

  // RAM window starts at byte 0x01000, i.e. address bits [19:12] == 1
  localparam logic [7:0]  RAM_PAGE       = 8'h01;

  localparam int          CTRL_WS_MSB    = 3;
  localparam int          CTRL_CLR_BIT   = 31;

  localparam logic [31:0] DEADBEEF       = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        r[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        r[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_avmm_responder_if.sv
// Avalon-MM slave port bundle between the NoC test fabric (master) and the responder.
interface noc_avmm_responder_if;
  logic [19:0] avmm_slave_address;
  logic        avmm_slave_write;
  logic        avmm_slave_read;
  logic [31:0] avmm_slave_writedata;
  logic [3:0]  avmm_slave_byteenable;
  logic        avmm_slave_waitrequest;
  logic [31:0] avmm_slave_readdata;
  logic        avmm_slave_readdatavalid;

  modport master (
    output avmm_slave_address, avmm_slave_write, avmm_slave_read,
           avmm_slave_writedata, avmm_slave_byteenable,
    input  avmm_slave_waitrequest, avmm_slave_readdata, avmm_slave_readdatavalid
  );

  modport slave (
    input  avmm_slave_address, avmm_slave_write, avmm_slave_read,
           avmm_slave_writedata, avmm_slave_byteenable,
    output avmm_slave_waitrequest, avmm_slave_readdata, avmm_slave_readdatavalid
  );
endinterface

// File: rtl/noc_avmm_responder_rd_pipe.sv
// Fixed-latency read response pipeline; data is forced to zero on bubbles so the
// output bus reads 0 whenever valid is low.
module noc_avmm_resp_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  // Shift register; reset drops every in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      data_q[0]  <= in_valid_i ? in_data_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/noc_avmm_responder.sv
// AVMM slave responder: ID/scratch/counter/CTRL registers plus a RAM, with
// programmable wait states and a pipelined fixed-latency read path.
module noc_avmm_responder
  import noc_avmm_resp_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = 32'h5EC7_0005,
  parameter int          RD_LATENCY = 2,
  parameter int          RAM_WORDS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  noc_avmm_responder_if.slave  avmm,
  output logic                 err_flag
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        init_q;
  logic [31:0] scratch_q, scratch_d;
  logic [3:0]  ws_q, ws_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic        err_q, err_d;
  logic [31:0] ram_q [RAM_WORDS];

  logic               cmd_s, waitreq_s, accept_s, abort_s;
  logic               wr_acc_s, rd_acc_s, both_s, clr_s;
  logic [17:0]        waddr_s;
  logic [9:0]         ram_off_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic               ram_hit_s, reg_hit_s, mapped_s;
  logic [31:0]        rd_mux_s;
  logic               unused_addr_s;

  assign cmd_s         = avmm.avmm_slave_read | avmm.avmm_slave_write;
  assign waddr_s       = avmm.avmm_slave_address[19:2];
  assign ram_off_s     = avmm.avmm_slave_address[11:2];
  assign ram_idx_s     = ram_off_s[RAM_AW-1:0];
  assign ram_hit_s     = (avmm.avmm_slave_address[19:12] == RAM_PAGE) &&
                         ({22'd0, ram_off_s} < 32'(RAM_WORDS));
  assign mapped_s      = ram_hit_s | reg_hit_s;
  assign unused_addr_s = ^avmm.avmm_slave_address[1:0];

  // FSM state register; init_q holds off acceptance for the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
    end
  end

  // FSM next state; counter loads N-1 because the IDLE cycle is the first stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_q && cmd_s && (ws_q != 4'd0)) begin
          state_d = ST_STALL;
          cnt_d   = ws_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          abort_s = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs: waitrequest and command acceptance
  always_comb begin
    waitreq_s = 1'b1;
    if (!init_q) begin
      waitreq_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:  waitreq_s = cmd_s && (ws_q != 4'd0);
        ST_STALL: waitreq_s = (cnt_q != 4'd0);
        default:  waitreq_s = 1'b1;
      endcase
    end
  end

  assign accept_s = cmd_s && !waitreq_s;
  assign wr_acc_s = accept_s && avmm.avmm_slave_write;
  assign rd_acc_s = accept_s && avmm.avmm_slave_read && !avmm.avmm_slave_write;
  assign both_s   = accept_s && avmm.avmm_slave_read && avmm.avmm_slave_write;
  assign clr_s    = wr_acc_s && !ram_hit_s && (waddr_s == WADDR_CTRL) &&
                    avmm.avmm_slave_byteenable[3] &&
                    avmm.avmm_slave_writedata[CTRL_CLR_BIT];

  // Read decode
  always_comb begin
    reg_hit_s = 1'b1;
    rd_mux_s  = DEADBEEF;
    if (ram_hit_s) begin
      rd_mux_s = ram_q[ram_idx_s];
    end else begin
      case (waddr_s)
        WADDR_ID:       rd_mux_s = ID_VALUE;
        WADDR_SCRATCH:  rd_mux_s = scratch_q;
        WADDR_WR_COUNT: rd_mux_s = wr_cnt_q;
        WADDR_RD_COUNT: rd_mux_s = rd_cnt_q;
        WADDR_CTRL:     rd_mux_s = {28'd0, ws_q};
        default: begin
          reg_hit_s = 1'b0;
          rd_mux_s  = DEADBEEF;
        end
      endcase
    end
  end

  // Register next state; an error event in the same cycle as a clear still sticks
  always_comb begin
    scratch_d = scratch_q;
    ws_d      = ws_q;
    err_d     = err_q;
    wr_cnt_d  = wr_acc_s ? (wr_cnt_q + 32'd1) : wr_cnt_q;
    rd_cnt_d  = rd_acc_s ? (rd_cnt_q + 32'd1) : rd_cnt_q;
    if (wr_acc_s && !ram_hit_s) begin
      case (waddr_s)
        WADDR_SCRATCH: scratch_d = be_merge(scratch_q, avmm.avmm_slave_writedata,
                                            avmm.avmm_slave_byteenable);
        WADDR_CTRL: begin
          if (avmm.avmm_slave_byteenable[0]) begin
            ws_d = avmm.avmm_slave_writedata[CTRL_WS_MSB:0];
          end else begin
            ws_d = ws_q;
          end
        end
        default: scratch_d = scratch_q;
      endcase
    end else begin
      scratch_d = scratch_q;
    end
    if (clr_s) begin
      wr_cnt_d = 32'd0;
      rd_cnt_d = 32'd0;
      err_d    = 1'b0;
    end else begin
      err_d = err_q;
    end
    if ((accept_s && !mapped_s) || both_s || abort_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= 32'd0;
      ws_q      <= 4'd0;
      wr_cnt_q  <= 32'd0;
      rd_cnt_q  <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      ws_q      <= ws_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

  // RAM write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s && ram_hit_s) begin
      ram_q[ram_idx_s] <= be_merge(ram_q[ram_idx_s], avmm.avmm_slave_writedata,
                                   avmm.avmm_slave_byteenable);
    end
  end

  noc_avmm_resp_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .WIDTH   (32)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rd_acc_s),
    .in_data_i   (rd_mux_s),
    .out_valid_o (avmm.avmm_slave_readdatavalid),
    .out_data_o  (avmm.avmm_slave_readdata)
  );

  assign avmm.avmm_slave_waitrequest = waitreq_s;
  assign err_flag                    = err_q;

endmodule

// File: tb/tb_noc_avmm_responder.sv
// Directed bench for noc_avmm_responder: reads push expectations into a scoreboard
// queue, a negedge monitor pops and compares on every readdatavalid.
module tb_noc_avmm_responder;

  localparam int RD_LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic err_flag;
  int   cyc;
  int   total;
  int   bad;
  int   rdv_cnt;
  int   rdv_cyc_q[$];
  exp_t sb_q[$];
  exp_t mon_e;

  noc_avmm_responder_if bus();

  noc_avmm_responder #(
    .ID_VALUE   (32'h5EC7_0005),
    .RD_LATENCY (RD_LAT),
    .RAM_WORDS  (256)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .avmm     (bus.slave),
    .err_flag (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.avmm_slave_readdatavalid === 1'b1) begin
      rdv_cnt++;
      rdv_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdv: got readdata %h, expected no response (cycle %0d)",
                 bus.avmm_slave_readdata, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_data", bus.avmm_slave_readdata, mon_e.data);
        check("rd_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      check("rdata_idle_zero", bus.avmm_slave_readdata, 32'h0);
    end
  end

  task automatic idle();
    bus.avmm_slave_read  = 1'b0;
    bus.avmm_slave_write = 1'b0;
  endtask

  // Drive a command at posedge+1, count stall cycles, return at posedge+1 after acceptance
  task automatic do_cmd(input logic rd, input logic wr, input logic [19:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic push, input logic [31:0] exp_d, output int stalls);
    bus.avmm_slave_read       = rd;
    bus.avmm_slave_write      = wr;
    bus.avmm_slave_address    = a;
    bus.avmm_slave_writedata  = d;
    bus.avmm_slave_byteenable = be;
    stalls = 0;
    @(negedge clk);
    while (bus.avmm_slave_waitrequest !== 1'b0 && stalls < 64) begin
      stalls++;
      @(negedge clk);
    end
    total++;
    if (stalls >= 64) begin
      bad++;
      $display("FAIL cmd_timeout: got %0d stall cycles, expected fewer than 64 at addr %h",
               stalls, a);
    end
    @(posedge clk);
    #1;
    if (push) sb_q.push_back('{exp_d, cyc + RD_LAT - 1});
  endtask

  task automatic rd(input logic [19:0] a, input logic [31:0] e, output int st);
    do_cmd(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, e, st);
    idle();
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be,
                    output int st);
    do_cmd(1'b0, 1'b1, a, d, be, 1'b0, 32'h0, st);
    idle();
  endtask

  initial begin
    int st;
    int n;
    int snap;
    total = 0;
    bad   = 0;
    rdv_cnt = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.avmm_slave_address    = 20'h0;
    bus.avmm_slave_writedata  = 32'h0;
    bus.avmm_slave_byteenable = 4'h0;
    idle();

    repeat (3) @(posedge clk);
    #1;
    check("rst_waitreq", 32'(bus.avmm_slave_waitrequest), 32'h1);
    check("rst_rdv", 32'(bus.avmm_slave_readdatavalid), 32'h0);
    check("rst_rdata", bus.avmm_slave_readdata, 32'h0);
    check("rst_err", 32'(err_flag), 32'h0);

    // Release and read ID: one stall cycle from the post-reset edge
    rst_n = 1'b1;
    rd(20'h00000, 32'h5EC7_0005, st);
    check("init_stall", 32'(st), 32'd1);

    wr(20'h00004, 32'hA5A5_A5A5, 4'b0011, st);
    rd(20'h00004, 32'h0000_A5A5, st);
    rd(20'h00008, 32'd1, st);
    rd(20'h0000C, 32'd3, st);

    wr(20'h00010, 32'd3, 4'hF, st);
    check("ws_set_stall", 32'(st), 32'd0);
    wr(20'h01010, 32'h1234_5678, 4'hF, st);
    check("ws3_wr_stall", 32'(st), 32'd3);
    rd(20'h01010, 32'h1234_5678, st);
    check("ws3_rd_stall", 32'(st), 32'd3);
    wr(20'h00010, 32'd0, 4'hF, st);

    for (int i = 0; i < 8; i++) begin
      wr(20'h01000 + 20'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF, st);
    end
    repeat (4) @(posedge clk);
    #1;
    rdv_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      do_cmd(1'b1, 1'b0, 20'h01000 + 20'(4 * i), 32'h0, 4'h0, 1'b1,
             32'hC0DE_0000 | 32'(i), st);
      check("b2b_stall", 32'(st), 32'd0);
    end
    idle();
    repeat (5) @(posedge clk);
    #1;
    n = rdv_cyc_q.size();
    check("b2b_count", 32'(n), 32'd8);
    if (n >= 8) check("b2b_span", 32'(rdv_cyc_q[n-1] - rdv_cyc_q[n-8]), 32'd7);

    // Byte write then read on the very next cycle
    wr(20'h01000, 32'hAB00_0000, 4'b1000, st);
    rd(20'h01000, 32'hABDE_0000, st);
    wr(20'h013FC, 32'h0BAD_F00D, 4'hF, st);
    rd(20'h013FC, 32'h0BAD_F00D, st);
    check("err_clean", 32'(err_flag), 32'h0);

    rd(20'h80000, 32'hDEAD_BEEF, st);
    check("err_unmapped_rd", 32'(err_flag), 32'h1);
    wr(20'h00010, 32'h8000_0000, 4'hF, st);
    check("err_cleared", 32'(err_flag), 32'h0);
    rd(20'h0000C, 32'd0, st);
    rd(20'h00008, 32'd0, st);

    wr(20'h01400, 32'h1111_1111, 4'hF, st);
    check("err_ram_past_end", 32'(err_flag), 32'h1);
    rd(20'h01400, 32'hDEAD_BEEF, st);
    wr(20'h00010, 32'h8000_0000, 4'hF, st);
    check("err_cleared2", 32'(err_flag), 32'h0);

    // Read+write together: write only, no response
    do_cmd(1'b1, 1'b1, 20'h00004, 32'h1111_2222, 4'hF, 1'b0, 32'h0, st);
    idle();
    check("err_rw_both", 32'(err_flag), 32'h1);
    rd(20'h00004, 32'h1111_2222, st);
    rd(20'h00008, 32'd1, st);
    rd(20'h0000C, 32'd2, st);

    // Clear and set WAIT_STATES=2 in one write, then abandon a stalled read
    wr(20'h00010, 32'h8000_0002, 4'hF, st);
    check("err_cleared3", 32'(err_flag), 32'h0);
    bus.avmm_slave_address = 20'h00000;
    bus.avmm_slave_read    = 1'b1;
    @(negedge clk);
    check("abort_waitreq", 32'(bus.avmm_slave_waitrequest), 32'h1);
    @(posedge clk);
    #1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("err_abort", 32'(err_flag), 32'h1);
    rd(20'h0000C, 32'd0, st);
    check("ws2_rd_stall", 32'(st), 32'd2);
    rd(20'h00008, 32'd0, st);
    wr(20'h00010, 32'd0, 4'hF, st);

    // Reset with two reads in flight: they must never respond
    repeat (4) @(posedge clk);
    #1;
    snap = rdv_cnt;
    do_cmd(1'b1, 1'b0, 20'h00000, 32'h0, 4'h0, 1'b0, 32'h0, st);
    do_cmd(1'b1, 1'b0, 20'h00004, 32'h0, 4'h0, 1'b0, 32'h0, st);
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_waitreq", 32'(bus.avmm_slave_waitrequest), 32'h1);
    check("rst2_err", 32'(err_flag), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst2_no_rdv", 32'(rdv_cnt - snap), 32'd0);
    rd(20'h00004, 32'h0, st);
    rd(20'h00010, 32'h0, st);

    repeat (6) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
